// File: rtl/reduce_pkg.sv
// Shared definitions for the reduce-dimension tiler and the downstream max-reduction stage.
package reduce_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefCols  = 8;

    // Index width that never collapses to zero bits for single-entry dimensions.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DefColW = clog2_min1(DefCols);

    typedef struct packed {
        logic               last;
        logic               tile_last;
        logic [DefColW-1:0] col_idx;
    } side_t;

endpackage

// File: rtl/reduce_dim_tiler_if.sv
// Stream bundle around the tiler: row-major input stream in, column-major grouped stream out.
interface reduce_dim_tiler_if
    import reduce_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned COL_W  = DefColW
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_tile_last;
    logic [COL_W-1:0]  out_col_idx;

    // master is the environment (producer + reducer); slave is the tiler.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_tile_last, out_col_idx
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_tile_last, out_col_idx
    );

endinterface

// File: rtl/reduce_tiler_bank_ram.sv
// Simple dual-port RAM holding both tile banks; bank select is the address MSB.
module reduce_tiler_bank_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/reduce_dim_tiler.sv
// Ping-pong tile buffer: accepts row-major tiles and re-emits them column-major so each
// reduction group (one column) arrives contiguously, tagged with group/tile end flags.
module reduce_dim_tiler
    import reduce_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 8
) (
    input logic               clk,
    input logic               rst,
    reduce_dim_tiler_if.slave bus
);

    localparam int unsigned RowW  = clog2_min1(ROWS);
    localparam int unsigned ColW  = clog2_min1(COLS);
    localparam int unsigned LocW  = clog2_min1(ROWS * COLS);
    localparam int unsigned AddrW = LocW + 1;
    localparam logic [RowW-1:0] RowMax = RowW'(ROWS - 1);
    localparam logic [ColW-1:0] ColMax = ColW'(COLS - 1);

    typedef struct packed {
        logic            last;
        logic            tile_last;
        logic [ColW-1:0] col_idx;
    } tside_t;

    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, rd_bank_q, iss_bank_q;
    logic [RowW-1:0]   wr_r_q, iss_r_q;
    logic [ColW-1:0]   wr_c_q, iss_c_q;
    logic              pend_q, skid_valid_q, out_valid_q;
    tside_t            pend_side_q, skid_side_q, out_side_q, iss_side;
    logic [DATA_W-1:0] skid_data_q, out_data_q, ram_rdata;
    logic [AddrW-1:0]  wr_addr, rd_addr;
    logic              in_ready, wr_fire, wr_tile_end, pop, iss_fire;
    logic [1:0]        occ;

    // Reads are issued ahead of consumption whenever the output register plus skid entry can
    // absorb everything in flight, which keeps one element per cycle across stalls and tiles.
    always_comb begin
        in_ready           = !full_q[wr_bank_q];
        wr_fire            = bus.in_valid && in_ready;
        wr_tile_end        = (wr_r_q == RowMax) && (wr_c_q == ColMax);
        pop                = out_valid_q && bus.out_ready;
        occ                = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(pend_q) - 2'(pop);
        iss_fire           = full_q[iss_bank_q] && (occ <= 2'd1);
        iss_side.last      = (iss_r_q == RowMax);
        iss_side.tile_last = (iss_r_q == RowMax) && (iss_c_q == ColMax);
        iss_side.col_idx   = iss_c_q;
        full_d             = full_q;
        if (wr_fire && wr_tile_end) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (pop && out_side_q.tile_last) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    assign wr_addr = {wr_bank_q, LocW'(32'(wr_r_q) * COLS + 32'(wr_c_q))};
    assign rd_addr = {iss_bank_q, LocW'(32'(iss_r_q) * COLS + 32'(iss_c_q))};

    reduce_tiler_bank_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (AddrW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_fire),
        .waddr_i (wr_addr),
        .wdata_i (bus.in_data),
        .re_i    (iss_fire),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q       <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            iss_bank_q   <= 1'b0;
            wr_r_q       <= '0;
            wr_c_q       <= '0;
            iss_r_q      <= '0;
            iss_c_q      <= '0;
            pend_q       <= 1'b0;
            pend_side_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_side_q  <= '0;
            skid_data_q  <= '0;
            out_valid_q  <= 1'b0;
            out_side_q   <= '0;
            out_data_q   <= '0;
        end else begin
            full_q <= full_d;
            if (wr_fire) begin
                if (wr_c_q == ColMax) begin
                    wr_c_q <= '0;
                    if (wr_r_q == RowMax) begin
                        wr_r_q    <= '0;
                        wr_bank_q <= ~wr_bank_q;
                    end else begin
                        wr_r_q <= wr_r_q + 1'b1;
                    end
                end else begin
                    wr_c_q <= wr_c_q + 1'b1;
                end
            end
            if (iss_fire) begin
                if (iss_r_q == RowMax) begin
                    iss_r_q <= '0;
                    if (iss_c_q == ColMax) begin
                        iss_c_q    <= '0;
                        iss_bank_q <= ~iss_bank_q;
                    end else begin
                        iss_c_q <= iss_c_q + 1'b1;
                    end
                end else begin
                    iss_r_q <= iss_r_q + 1'b1;
                end
            end
            pend_q      <= iss_fire;
            pend_side_q <= iss_side;
            if (pop && out_side_q.tile_last) begin
                rd_bank_q <= ~rd_bank_q;
            end
            if (!out_valid_q || pop) begin
                if (skid_valid_q) begin
                    out_valid_q  <= 1'b1;
                    out_data_q   <= skid_data_q;
                    out_side_q   <= skid_side_q;
                    skid_valid_q <= pend_q;
                    skid_data_q  <= ram_rdata;
                    skid_side_q  <= pend_side_q;
                end else if (pend_q) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= ram_rdata;
                    out_side_q  <= pend_side_q;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (pend_q) begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= ram_rdata;
                skid_side_q  <= pend_side_q;
            end
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_last      = out_side_q.last;
    assign bus.out_tile_last = out_side_q.tile_last;
    assign bus.out_col_idx   = out_side_q.col_idx;

endmodule

// File: tb/tb_reduce_dim_tiler.sv
// Directed bench for reduce_dim_tiler with a 4x3 tile: ordering, flags, latency, back-pressure, reset.
module tb_reduce_dim_tiler;

    localparam int unsigned DW = 32;
    localparam int unsigned R  = 4;
    localparam int unsigned C  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reduce_dim_tiler_if #(.DATA_W(DW), .COL_W(2)) bus ();

    reduce_dim_tiler #(.DATA_W(DW), .ROWS(R), .COLS(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] feed_q[$];
    logic [35:0] got_q[$];
    int          got_cyc[$];
    int          in_cyc[$];

    // Column-major order of a row-major 4x3 tile, worked out by hand.
    int exp_seq[12] = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};

    // {data, last, tile_last, col_idx} expected for element i of a tile whose inputs start at base.
    function automatic logic [35:0] exp_elem(input int base, input int i);
        logic [31:0] d;
        d = 32'(base + exp_seq[i]);
        return {d, (i % 4 == 3), (i == 11), 2'(i / 4)};
    endfunction

    task automatic step();
        logic [31:0] dummy;
        bus.in_valid = (feed_q.size() > 0);
        bus.in_data  = (feed_q.size() > 0) ? feed_q[0] : '0;
        if (bus.in_valid && bus.in_ready) begin
            dummy = feed_q.pop_front();
            in_cyc.push_back(cyc);
        end
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back({bus.out_data, bus.out_last, bus.out_tile_last, bus.out_col_idx});
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_logs();
        feed_q.delete();
        got_q.delete();
        got_cyc.delete();
        in_cyc.delete();
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_last !== 1'b0) begin
            errors++; $display("FAIL reset_out_last got %b want 0", bus.out_last);
        end
        checks++;
        if (bus.out_tile_last !== 1'b0) begin
            errors++; $display("FAIL reset_out_tile_last got %b want 0", bus.out_tile_last);
        end
        checks++;
        if (bus.out_col_idx !== 2'd0) begin
            errors++; $display("FAIL reset_out_col_idx got %0d want 0", bus.out_col_idx);
        end
        checks++;
        if (bus.out_data !== 32'd0) begin
            errors++; $display("FAIL reset_out_data got %h want 0", bus.out_data);
        end
    endtask

    task automatic test_single_tile();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) feed_q.push_back(32'(i));
        for (int k = 0; k < 100 && got_q.size() < 12; k++) step();
        repeat (10) step();
        checks++;
        if (got_q.size() != 12) begin
            errors++; $display("FAIL single_count got %0d want 12", got_q.size());
        end
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_elem(0, i)) begin
                errors++; $display("FAIL single_elem[%0d] got %h want %h", i, got_q[i], exp_elem(0, i));
            end
        end
        checks++;
        if (in_cyc.size() != 12) begin
            errors++; $display("FAIL single_in_count got %0d want 12", in_cyc.size());
        end else if (got_cyc.size() > 0) begin
            checks++;
            if (got_cyc[0] - in_cyc[11] != 3) begin
                errors++; $display("FAIL single_latency got %0d want 3", got_cyc[0] - in_cyc[11]);
            end
        end
        for (int i = 1; i < got_cyc.size(); i++) begin
            checks++;
            if (got_cyc[i] != got_cyc[0] + i) begin
                errors++; $display("FAIL single_gap[%0d] got cycle %0d want %0d", i, got_cyc[i], got_cyc[0] + i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int rise;
        do_reset();
        for (int i = 0; i < 12; i++) feed_q.push_back(32'(i));
        for (int i = 0; i < 12; i++) feed_q.push_back(32'(100 + i));
        repeat (60) step();
        checks++;
        if (in_cyc.size() != 24) begin
            errors++; $display("FAIL b2b_handshakes got %0d want 24", in_cyc.size());
        end else begin
            checks++;
            if (in_cyc[23] - in_cyc[0] != 23) begin
                errors++; $display("FAIL b2b_in_span got %0d want 23", in_cyc[23] - in_cyc[0]);
            end
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_in_ready_full got %b want 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd0) begin
            errors++; $display("FAIL b2b_stalled_head got valid=%b data=%h want valid=1 data=0",
                               bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        rise = -1;
        for (int k = 0; k < 80 && got_q.size() < 24; k++) begin
            if (rise < 0 && bus.in_ready === 1'b1) rise = cyc;
            step();
        end
        checks++;
        if (got_q.size() != 24) begin
            errors++; $display("FAIL b2b_count got %0d want 24", got_q.size());
        end
        for (int i = 0; i < 24 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_elem((i / 12) * 100, i % 12)) begin
                errors++; $display("FAIL b2b_elem[%0d] got %h want %h", i, got_q[i],
                                   exp_elem((i / 12) * 100, i % 12));
            end
        end
        for (int i = 1; i < got_cyc.size(); i++) begin
            checks++;
            if (got_cyc[i] != got_cyc[0] + i) begin
                errors++; $display("FAIL b2b_gap[%0d] got cycle %0d want %0d", i, got_cyc[i], got_cyc[0] + i);
            end
        end
        if (got_cyc.size() >= 12) begin
            checks++;
            if (rise != got_cyc[11] + 1) begin
                errors++; $display("FAIL b2b_in_ready_rise got cycle %0d want %0d", rise, got_cyc[11] + 1);
            end
        end
    endtask

    task automatic test_random_stall();
        logic        prev_stall;
        logic [35:0] prev, cur;
        do_reset();
        for (int i = 0; i < 12; i++) feed_q.push_back(32'(i));
        prev_stall = 1'b0;
        prev       = '0;
        for (int k = 0; k < 400 && got_q.size() < 12; k++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            cur = {bus.out_data, bus.out_last, bus.out_tile_last, bus.out_col_idx};
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || cur !== prev) begin
                    errors++; $display("FAIL stall_hold got valid=%b %h want valid=1 %h", bus.out_valid, cur, prev);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev       = cur;
            step();
        end
        checks++;
        if (got_q.size() != 12) begin
            errors++; $display("FAIL stall_count got %0d want 12", got_q.size());
        end
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_elem(0, i)) begin
                errors++; $display("FAIL stall_elem[%0d] got %h want %h", i, got_q[i], exp_elem(0, i));
            end
        end
    endtask

    task automatic test_stream();
        do_reset();
        bus.out_ready = 1'b1;
        for (int t = 0; t < 4; t++)
            for (int i = 0; i < 12; i++) feed_q.push_back(32'(t * 100 + i));
        for (int k = 0; k < 300 && got_q.size() < 48; k++) step();
        checks++;
        if (got_q.size() != 48) begin
            errors++; $display("FAIL stream_count got %0d want 48", got_q.size());
        end
        for (int i = 0; i < 48 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_elem((i / 12) * 100, i % 12)) begin
                errors++; $display("FAIL stream_elem[%0d] got %h want %h", i, got_q[i],
                                   exp_elem((i / 12) * 100, i % 12));
            end
            if (i % 12 != 0) begin
                checks++;
                if (got_cyc[i] != got_cyc[i - 1] + 1) begin
                    errors++; $display("FAIL stream_gap[%0d] got cycle %0d want %0d", i, got_cyc[i],
                                       got_cyc[i - 1] + 1);
                end
            end
        end
        if (got_cyc.size() > 0 && in_cyc.size() >= 12) begin
            checks++;
            if (got_cyc[0] - in_cyc[11] != 3) begin
                errors++; $display("FAIL stream_latency got %0d want 3", got_cyc[0] - in_cyc[11]);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) feed_q.push_back(32'(50 + i));
        for (int k = 0; k < 20 && in_cyc.size() < 5; k++) step();
        checks++;
        if (in_cyc.size() != 5) begin
            errors++; $display("FAIL fill_abort_in got %0d want 5", in_cyc.size());
        end
        do_reset();
        bus.out_ready = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL fill_abort_state got valid=%b ready=%b want valid=0 ready=1",
                               bus.out_valid, bus.in_ready);
        end
        for (int i = 0; i < 12; i++) feed_q.push_back(32'(i));
        for (int k = 0; k < 100 && got_q.size() < 12; k++) step();
        repeat (20) step();
        checks++;
        if (got_q.size() != 12) begin
            errors++; $display("FAIL fill_abort_count got %0d want 12", got_q.size());
        end
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_elem(0, i)) begin
                errors++; $display("FAIL fill_abort_elem[%0d] got %h want %h", i, got_q[i], exp_elem(0, i));
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) feed_q.push_back(32'(i));
        for (int k = 0; k < 60 && got_q.size() < 4; k++) step();
        checks++;
        if (got_q.size() != 4) begin
            errors++; $display("FAIL drain_abort_pre got %0d want 4", got_q.size());
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_abort_valid got %b want 0", bus.out_valid);
        end
        rst = 1'b0;
        clear_logs();
        repeat (30) step();
        checks++;
        if (got_q.size() != 0) begin
            errors++; $display("FAIL drain_abort_residue got %0d outputs want 0", got_q.size());
        end
        for (int i = 0; i < 12; i++) feed_q.push_back(32'(200 + i));
        for (int k = 0; k < 100 && got_q.size() < 12; k++) step();
        checks++;
        if (got_q.size() != 12) begin
            errors++; $display("FAIL drain_abort_count got %0d want 12", got_q.size());
        end
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_elem(200, i)) begin
                errors++; $display("FAIL drain_abort_elem[%0d] got %h want %h", i, got_q[i], exp_elem(200, i));
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_tile();
        test_back_to_back();
        test_random_stall();
        test_stream();
        test_reset_mid_fill();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
